xilinx_rst_boot_ctrl: RTL

//  Board-level reset/boot sequencer feeding the FPGA top's SoC reset, boot-mode and RTC inputs.

---
 rtl/xilinx_rst_boot_ctrl_pkg.sv | 14 +
 rtl/xilinx_rst_boot_ctrl_debounce.sv | 51 +++++
 rtl/xilinx_rst_boot_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xilinx_rst_boot_ctrl_pkg.sv
// Shared types for the board reset/boot sequencer.
package xilinx_rst_boot_pkg;

  // Sequencer state; the encoding is visible on state_o for ILA debug.
  typedef enum logic [1:0] {
    ST_LOCK_WAIT = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_ASSERT    = 2'd3
  } rbc_state_e;

  typedef logic [1:0] boot_mode_t;

endpackage

// File: rtl/xilinx_rst_boot_ctrl_debounce.sv
// Push-button conditioning: 2-flop synchroniser followed by a stable-count
// debouncer. The output level only flips after DebounceCycles consecutive
// cycles of disagreement with the current level.
module rst_btn_debounce #(
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            meta_r;
  logic            sync_r;
  logic            level_r;
  logic [CntW-1:0] cnt_r;

  // Bring the asynchronous button into the clk_i domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= raw_i;
      sync_r <= meta_r;
    end
  end

  // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_r <= 1'b0;
      cnt_r   <= CntW'(0);
    end else if (sync_r != level_r) begin
      if (cnt_r == CntLast) begin
        level_r <= ~level_r;
        cnt_r   <= CntW'(0);
      end else begin
        cnt_r   <= cnt_r + CntW'(1);
      end
    end else begin
      cnt_r <= CntW'(0);
    end
  end

  assign level_o = level_r;

endmodule

// File: rtl/xilinx_rst_boot_ctrl.sv
// Board-level reset/boot sequencer: waits for clock lock, stretches reset,
// latches the boot mode at release and gates the RTC divider to RUN only.
module xilinx_rst_boot_ctrl
  import xilinx_rst_boot_pkg::*;
#(
  parameter int unsigned DebounceCycles = 500000,
  parameter int unsigned HoldCycles     = 1024,
  parameter int unsigned RtcDiv         = 50
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       locked_i,
  input  logic       btn_rst_i,
  input  logic       vio_rst_i,
  input  logic       test_mode_i,
  input  logic [1:0] boot_mode_i,
  output logic       soc_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       rtc_o,
  output logic [1:0] state_o
);

  localparam int unsigned HoldW = $clog2(HoldCycles + 1);
  localparam int unsigned RtcW  = $clog2(RtcDiv + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);
  localparam logic [RtcW-1:0]  RtcHalf  = RtcW'(RtcDiv / 2 - 1);

  logic             lock_meta_r;
  logic             lock_sync_r;
  logic             btn_level_s;
  logic             rst_req_s;
  rbc_state_e       state_r;
  logic             soc_rst_n_r;
  boot_mode_t       boot_mode_r;
  logic             rtc_r;
  logic [HoldW-1:0] hold_cnt_r;
  logic [RtcW-1:0]  rtc_cnt_r;

  rst_btn_debounce #(
    .DebounceCycles(DebounceCycles)
  ) u_btn_debounce (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (btn_rst_i),
    .level_o(btn_level_s)
  );

  assign rst_req_s = btn_level_s | vio_rst_i;

  // Two-flop synchroniser for the clock-wizard lock indication.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= locked_i;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Sequencer FSM with hold counter, RTC divider and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_LOCK_WAIT;
      soc_rst_n_r <= 1'b0;
      boot_mode_r <= 2'b00;
      rtc_r       <= 1'b0;
      hold_cnt_r  <= HoldW'(0);
      rtc_cnt_r   <= RtcW'(0);
    end else begin
      case (state_r)
        ST_LOCK_WAIT: begin
          soc_rst_n_r <= 1'b0;
          rtc_r       <= 1'b0;
          rtc_cnt_r   <= RtcW'(0);
          hold_cnt_r  <= HoldW'(0);
          if (lock_sync_r) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_LOCK_WAIT;
          end
        end
        ST_HOLD: begin
          rtc_r     <= 1'b0;
          rtc_cnt_r <= RtcW'(0);
          if (!lock_sync_r) begin
            state_r     <= ST_LOCK_WAIT;
            soc_rst_n_r <= 1'b0;
            hold_cnt_r  <= HoldW'(0);
          end else if (rst_req_s) begin
            state_r     <= ST_ASSERT;
            soc_rst_n_r <= 1'b0;
            hold_cnt_r  <= HoldW'(0);
          end else if (hold_cnt_r == HoldLast) begin
            // Release: boot mode is captured on the same edge soc_rst_no rises.
            state_r     <= ST_RUN;
            soc_rst_n_r <= 1'b1;
            boot_mode_r <= boot_mode_i;
            hold_cnt_r  <= HoldW'(0);
          end else begin
            soc_rst_n_r <= 1'b0;
            hold_cnt_r  <= hold_cnt_r + HoldW'(1);
          end
        end
        ST_RUN: begin
          hold_cnt_r <= HoldW'(0);
          if (!lock_sync_r) begin
            state_r     <= ST_LOCK_WAIT;
            soc_rst_n_r <= 1'b0;
            rtc_r       <= 1'b0;
            rtc_cnt_r   <= RtcW'(0);
          end else if (rst_req_s) begin
            state_r     <= ST_ASSERT;
            soc_rst_n_r <= 1'b0;
            rtc_r       <= 1'b0;
            rtc_cnt_r   <= RtcW'(0);
          end else if (rtc_cnt_r == RtcHalf) begin
            soc_rst_n_r <= 1'b1;
            rtc_r       <= ~rtc_r;
            rtc_cnt_r   <= RtcW'(0);
          end else begin
            soc_rst_n_r <= 1'b1;
            rtc_cnt_r   <= rtc_cnt_r + RtcW'(1);
          end
        end
        ST_ASSERT: begin
          soc_rst_n_r <= 1'b0;
          rtc_r       <= 1'b0;
          rtc_cnt_r   <= RtcW'(0);
          hold_cnt_r  <= HoldW'(0);
          if (!lock_sync_r) begin
            state_r <= ST_LOCK_WAIT;
          end else if (!btn_level_s && !vio_rst_i) begin
            state_r <= ST_HOLD;
          end else begin
            state_r <= ST_ASSERT;
          end
        end
        default: begin
          state_r     <= ST_LOCK_WAIT;
          soc_rst_n_r <= 1'b0;
          rtc_r       <= 1'b0;
          rtc_cnt_r   <= RtcW'(0);
          hold_cnt_r  <= HoldW'(0);
        end
      endcase
    end
  end

  // DFT bypass lets the tester drive SoC reset straight from the board pin.
  assign soc_rst_no  = test_mode_i ? rst_ni : soc_rst_n_r;
  assign boot_mode_o = boot_mode_r;
  assign rtc_o       = rtc_r;
  assign state_o     = state_r;

endmodule
